line_fetcher: RTL and testbench

LINE_FETCHER -- requirements
Module: line_fetcher

---
 rtl/line_fetcher.sv | 131 +++++++++++++
 tb/tb_line_fetcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetcher.sv
// line_fetcher: copies one display line from SDRAM into one half of the line
// buffer. The line is read as BURST_LEN-word bursts, and the frame generator
// gets a toggle acknowledge once the whole line has been written.
module line_fetcher #(
  parameter int WORDS_PER_LINE = 640,
  parameter int BURST_LEN      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        g_req,
  output logic        g_ack,
  input  logic        g_cache_row,
  input  logic [9:0]  g_sdram_row,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [19:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        wr_en,
  output logic [10:0] wr_address,
  output logic [15:0] wr_data,
  output logic        busy
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [9:0]     LAST_WORD = 10'(WORDS_PER_LINE - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  logic [1:0]     state;
  logic           req_lat;
  logic           cache_lat;
  logic [9:0]     row_lat;
  logic [9:0]     word_cnt;
  logic [BCW-1:0] burst_cnt;

  // Stage p0: the word returned by SDRAM, registered once before the buffer write
  logic           vld_p0;
  logic [15:0]    data_p0;
  logic           cap_p0;
  logic           beat_last;

  // The final beat of a burst is being written now, so nothing more belongs to this burst
  assign beat_last = vld_p0 && (burst_cnt == LAST_BEAT);
  // Only words that arrive during DATA are captured; anything else is stray traffic
  assign cap_p0    = mem_rvalid && (state == S_DATA) && !beat_last;

  assign wr_en      = vld_p0;
  assign wr_data    = data_p0;
  assign wr_address = {cache_lat, word_cnt};
  assign busy       = (state != S_IDLE);

  // Capture returned read words; reset drops any word still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= cap_p0;
      if (cap_p0) begin
        data_p0 <= mem_rdata;
      end
    end
  end

  // Fetch sequencer: latch the request, issue bursts, count written words, acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      g_ack     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      req_lat   <= 1'b0;
      cache_lat <= 1'b0;
      row_lat   <= '0;
      word_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (g_req != g_ack) begin
            req_lat   <= g_req;
            cache_lat <= g_cache_row;
            row_lat   <= g_sdram_row;
            word_cnt  <= '0;
            burst_cnt <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= {g_sdram_row, 10'd0};
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (vld_p0) begin
            if (burst_cnt == LAST_BEAT) begin
              burst_cnt <= '0;
              if (word_cnt == LAST_WORD) begin
                // Hold the counter on the last word so the address never leaves the line
                state <= S_DONE;
              end else begin
                word_cnt <= word_cnt + 10'd1;
                mem_req  <= 1'b1;
                mem_addr <= {row_lat, word_cnt + 10'd1};
                state    <= S_REQ;
              end
            end else begin
              word_cnt  <= word_cnt + 10'd1;
              burst_cnt <= burst_cnt + BCW'(1);
            end
          end
        end
        S_DONE: begin
          g_ack <= req_lat;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetcher.sv
// tb_line_fetcher: directed bench for line_fetcher with an SDRAM model
// that can stall acceptance, leave gaps inside a burst or inject stray words.
module tb_line_fetcher;

  localparam int WPL = 640;
  localparam int BL  = 8;
  localparam int LAT = 2 + (WPL / BL) * (2 + BL);

  logic        clk;
  logic        reset;
  logic        g_req;
  logic        g_ack;
  logic        g_cache_row;
  logic [9:0]  g_sdram_row;
  logic        mem_req;
  logic        mem_ack;
  logic [19:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        wr_en;
  logic [10:0] wr_address;
  logic [15:0] wr_data;
  logic        busy;

  line_fetcher #(.WORDS_PER_LINE(WPL), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .g_req(g_req), .g_ack(g_ack),
    .g_cache_row(g_cache_row), .g_sdram_row(g_sdram_row),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model controls and observations
  int          stall_cycles = 0;
  bit          gap_mode     = 1'b0;
  int          inj_cnt      = 0;
  int          remaining    = 0;
  int          stall_cnt    = 0;
  int          gap_tick     = 0;
  logic [19:0] b_addr       = '0;
  logic [19:0] exp_baddr    = '0;
  logic [19:0] last_baddr   = '0;
  int          addr_err     = 0;
  int          nbursts      = 0;

  // write monitor observations
  logic [15:0] lbuf [0:2047];
  bit          seen [0:2047];
  logic [10:0] exp_wa  = '0;
  logic [10:0] last_wa = '0;
  int          nwr      = 0;
  int          seq_err  = 0;
  int          stab_err = 0;
  int          stall_wr = 0;
  int          spur     = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rv  = 1'b0;
  logic [19:0] prev_addr = '0;

  function automatic logic [15:0] memf(input logic [19:0] a);
    return {a[15:10] ^ a[5:0], a[9:0]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(input logic [10:0] wa0, input logic [19:0] ba0);
    nwr = 0; seq_err = 0; stab_err = 0; stall_wr = 0; spur = 0;
    addr_err = 0; nbursts = 0;
    exp_wa = wa0; exp_baddr = ba0;
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
  endtask

  task automatic wait_ack(input logic val, input int limit, output int cyc);
    cyc = 0;
    while (g_ack !== val && cyc < limit) begin
      tick;
      cyc++;
    end
  endtask

  task automatic check_line(input string tag, input logic cache, input logic [9:0] row);
    int errs;
    logic [10:0] a;
    errs = 0;
    for (int w = 0; w < WPL; w++) begin
      a = {cache, 10'(w)};
      if (!seen[a] || lbuf[a] !== memf({row, 10'(w)})) errs++;
    end
    chk(tag, errs, 0);
  endtask

  // SDRAM model: drives shortly after each rising edge
  initial begin
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
      gap_tick++;
      if (inj_cnt > 0) begin
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; inj_cnt--;
      end else if (remaining > 0) begin
        if (!(gap_mode && (gap_tick % 3 == 1))) begin
          mem_rvalid = 1'b1; mem_rdata = memf(b_addr);
          b_addr = b_addr + 20'd1; remaining--;
        end
      end else if (mem_req === 1'b1) begin
        if (stall_cnt < stall_cycles) stall_cnt++;
        else begin
          mem_ack = 1'b1; stall_cnt = 0;
          if (mem_addr !== exp_baddr) addr_err++;
          exp_baddr = exp_baddr + 20'(BL);
          last_baddr = mem_addr; nbursts++;
          b_addr = mem_addr; remaining = BL;
        end
      end
    end
  end

  // write / handshake monitor on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (wr_address !== exp_wa) seq_err++;
        exp_wa = wr_address + 11'd1;
        last_wa = wr_address;
        seen[wr_address] = 1'b1;
        lbuf[wr_address] = wr_data;
        nwr++;
        if (mem_req === 1'b1) stall_wr++;
        if (prev_rv !== 1'b1) spur++;
      end
      if (prev_req === 1'b1 && prev_ack === 1'b0 && reset === 1'b0) begin
        if (mem_req !== 1'b1 || mem_addr !== prev_addr) stab_err++;
      end
      prev_req = mem_req; prev_addr = mem_addr; prev_ack = mem_ack; prev_rv = mem_rvalid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [10:0] wa0;
    reset = 1'b1; g_req = 1'b0; g_cache_row = 1'b0; g_sdram_row = '0;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_g_ack", g_ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_address", wr_address, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);

    // basic line fetch: cache half 1, row 0x005
    clear_mon(11'h400, {10'h005, 10'd0});
    g_cache_row = 1'b1; g_sdram_row = 10'h005; g_req = 1'b1;
    wait_ack(1'b1, 3000, cyc);
    chk("t1_latency", cyc, LAT);
    chk("t1_writes", nwr, WPL);
    chk("t1_seq", seq_err, 0);
    chk("t1_last_wa", last_wa, 11'h67F);
    chk("t1_burst_addr", addr_err, 0);
    chk("t1_bursts", nbursts, WPL / BL);
    chk("t1_last_burst", last_baddr, 20'h01678);
    chk("t1_busy_after", busy, 0);
    check_line("t1_data", 1'b1, 10'h005);

    // acceptance stalled 5 cycles per burst
    stall_cycles = 5;
    clear_mon(11'h000, {10'h03A, 10'd0});
    g_cache_row = 1'b0; g_sdram_row = 10'h03A; g_req = 1'b0;
    wait_ack(1'b0, 5000, cyc);
    chk("t2_latency", cyc, LAT + (WPL / BL) * 5);
    chk("t2_req_stable", stab_err, 0);
    chk("t2_write_in_stall", stall_wr, 0);
    chk("t2_writes", nwr, WPL);
    chk("t2_seq", seq_err, 0);
    check_line("t2_data", 1'b0, 10'h03A);
    stall_cycles = 0;

    // inputs change mid-fetch and the request toggles back while busy
    clear_mon(11'h000, {10'h011, 10'd0});
    g_cache_row = 1'b0; g_sdram_row = 10'h011; g_req = 1'b1;
    repeat (100) tick;
    g_sdram_row = 10'h2AA; g_cache_row = 1'b1; g_req = 1'b0;
    wait_ack(1'b1, 3000, cyc);
    chk("t4_latency", 100 + cyc, LAT);
    chk("t4_writes", nwr, WPL);
    chk("t4_seq", seq_err, 0);
    chk("t4_burst_addr", addr_err, 0);
    check_line("t4_data", 1'b0, 10'h011);
    chk("t4_idle_after_done", busy, 0);
    clear_mon(11'h400, {10'h2AA, 10'd0});
    tick;
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_req", mem_req, 1);
    chk("t4_restart_addr", mem_addr, {10'h2AA, 10'd0});
    wait_ack(1'b0, 3000, cyc);
    chk("t4b_latency", 1 + cyc, LAT);
    chk("t4b_writes", nwr, WPL);
    check_line("t4b_data", 1'b1, 10'h2AA);

    // gaps inside bursts, top row
    gap_mode = 1'b1;
    clear_mon(11'h400, {10'h3FF, 10'd0});
    g_cache_row = 1'b1; g_sdram_row = 10'h3FF; g_req = 1'b1;
    wait_ack(1'b1, 5000, cyc);
    chk("t3_slower", (cyc > LAT && cyc < 5000) ? 1 : 0, 1);
    chk("t3_writes", nwr, WPL);
    chk("t3_seq", seq_err, 0);
    chk("t3_spurious", spur, 0);
    chk("t3_burst_addr", addr_err, 0);
    check_line("t3_data", 1'b1, 10'h3FF);
    gap_mode = 1'b0;

    // reset at word 300, request left pending through reset
    clear_mon(11'h000, {10'h007, 10'd0});
    g_cache_row = 1'b0; g_sdram_row = 10'h007; g_req = 1'b0;
    cyc = 0;
    while (nwr < 300 && cyc < 4000) begin
      tick;
      cyc++;
    end
    chk("t5_reach_300", nwr, 300);
    reset = 1'b1; g_req = 1'b1;
    clear_mon(11'h000, {10'h007, 10'd0});
    tick;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_g_ack", g_ack, 0);
    chk("t5_idle", busy, 0);
    chk("t5_mem_req", mem_req, 0);
    reset = 1'b0;
    repeat (3) tick;
    chk("t5_late_writes", nwr, 0);
    wait_ack(1'b1, 4000, cyc);
    chk("t5_pending_ack", g_ack, 1);
    chk("t5_writes", nwr, WPL);
    chk("t5_seq", seq_err, 0);
    check_line("t5_data", 1'b0, 10'h007);

    // stray read words while idle
    tick;
    clear_mon(11'h000, 20'd0);
    wa0 = wr_address;
    inj_cnt = 4;
    repeat (6) tick;
    chk("t6_writes", nwr, 0);
    chk("t6_addr_kept", wr_address, wa0);
    chk("t6_busy", busy, 0);
    chk("t6_g_ack", g_ack, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
